// File: rtl/scan_index_gen_if.sv
// scan_index_gen_if: key inputs and scan outputs of scan_index_gen.
// key_mode/key_step raw active-low keys; a,b,c select; mode; tick.
interface scan_index_gen_if;
   logic       key_mode;
   logic       key_step;
   logic       a;
   logic       b;
   logic       c;
   logic [1:0] mode;
   logic       tick;

   modport master (
      output key_mode, key_step,
      input  a, b, c, mode, tick
   );

   modport slave (
      input  key_mode, key_step,
      output a, b, c, mode, tick
   );
endinterface

// File: rtl/scan_index_gen.sv
// scan_index_gen: 3-bit LED-decoder select with debounced mode/step keys.
// Ports: clk, rst_n (async low), bus (slave: keys in; a,b,c,mode,tick out).
module scan_index_gen #(
   parameter int CLK_FREQ_HZ  = 50_000_000,
   parameter int STEP_HZ      = 2,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input logic             clk,
   input logic             rst_n,
   scan_index_gen_if.slave bus
);
   localparam int DIV = CLK_FREQ_HZ / STEP_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [DW-1:0] D_PRE  = DW'(DEBOUNCE_CYC - 2);

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      PING = 2'd3
   } mode_e;

   // Bit 0 is the mode key, bit 1 the step key.
   logic [1:0]    raw;
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    prev_q;
   logic [1:0]    lvl_q;
   logic [1:0]    lvl_dly_q;
   logic [DW-1:0] cnt_q [2];
   logic [1:0]    press;

   mode_e         mode_q;
   logic [2:0]    idx_q;
   logic          dir_up_q;
   logic          tick_q;
   logic [PW-1:0] presc_q;
   logic          wrap;
   logic          mode_pr;
   logic          step_pr;

   assign raw     = {bus.key_step, bus.key_mode};
   assign press   = lvl_dly_q & ~lvl_q;
   assign mode_pr = press[0];
   assign step_pr = press[1];
   assign wrap    = (presc_q == P_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         prev_q    <= '1;
         lvl_q     <= '1;
         lvl_dly_q <= '1;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         lvl_dly_q <= lvl_q;
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] != prev_q[k]) begin
               cnt_q[k] <= '0;
            end else if (cnt_q[k] != D_LAST) begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
            // Level is accepted on the cycle the count reaches its last value.
            if (sync2_q[k] == prev_q[k] && cnt_q[k] >= D_PRE) begin
               lvl_q[k] <= sync2_q[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= HOLD;
         idx_q    <= 3'd0;
         dir_up_q <= 1'b1;
         tick_q   <= 1'b0;
         presc_q  <= '0;
      end else begin
         tick_q <= 1'b0;
         if (mode_pr) begin
            // A mode press restarts the step period and swallows any wrap.
            presc_q <= '0;
            unique case (mode_q)
               HOLD: mode_q <= UP;
               UP:   mode_q <= DOWN;
               DOWN: begin
                  mode_q   <= PING;
                  dir_up_q <= 1'b1;
               end
               PING: mode_q <= HOLD;
            endcase
            if (mode_q == HOLD && step_pr) begin
               idx_q <= idx_q + 3'd1;
            end
         end else begin
            presc_q <= wrap ? '0 : presc_q + 1'b1;
            tick_q  <= wrap;
            if (mode_q == HOLD) begin
               if (step_pr) begin
                  idx_q <= idx_q + 3'd1;
               end
            end else if (wrap) begin
               unique case (mode_q)
                  HOLD: ;
                  UP:   idx_q <= idx_q + 3'd1;
                  DOWN: idx_q <= idx_q - 3'd1;
                  PING: begin
                     // Turn around at the ends so endpoints never repeat.
                     if (dir_up_q) begin
                        if (idx_q == 3'd7) begin
                           dir_up_q <= 1'b0;
                           idx_q    <= 3'd6;
                        end else begin
                           idx_q <= idx_q + 3'd1;
                        end
                     end else begin
                        if (idx_q == 3'd0) begin
                           dir_up_q <= 1'b1;
                           idx_q    <= 3'd1;
                        end else begin
                           idx_q <= idx_q - 3'd1;
                        end
                     end
                  end
               endcase
            end
         end
      end
   end

   assign bus.a    = idx_q[2];
   assign bus.b    = idx_q[1];
   assign bus.c    = idx_q[0];
   assign bus.mode = mode_q;
   assign bus.tick = tick_q;
endmodule

// File: tb/tb_scan_index_gen.sv
// tb_scan_index_gen: directed bench for scan_index_gen.
// DIV=10, DEBOUNCE_CYC=4; keys driven and outputs sampled on negedge.
module tb_scan_index_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   lat;

   scan_index_gen_if bus();

   scan_index_gen #(
      .CLK_FREQ_HZ (100),
      .STEP_HZ     (10),
      .DEBOUNCE_CYC(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         key;
      int         low;
      bit         bounce;
      logic [2:0] e_idx;
      logic [1:0] e_mode;
      string      nm;
   } vec_t;

   vec_t tbl[11];

   function automatic logic [2:0] idx();
      return {bus.a, bus.b, bus.c};
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic drive_key(input bit k, input logic v);
      if (k) bus.key_step = v;
      else   bus.key_mode = v;
   endtask

   task automatic pulse_key(input bit k, input int low, input bit bounce);
      if (bounce) begin
         drive_key(k, 1'b0); repeat (2) @(negedge clk);
         drive_key(k, 1'b1); repeat (2) @(negedge clk);
      end
      drive_key(k, 1'b0);
      repeat (low) @(negedge clk);
      drive_key(k, 1'b1);
      if (bounce) begin
         repeat (2) @(negedge clk);
         drive_key(k, 1'b0); repeat (2) @(negedge clk);
         drive_key(k, 1'b1);
      end
      repeat (14) @(negedge clk);
   endtask

   task automatic press_mode_wait(input logic [1:0] exp, input bit with_step,
                                  output int n);
      bus.key_mode = 1'b0;
      if (with_step) bus.key_step = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (n == 5) begin
            bus.key_mode = 1'b1;
            bus.key_step = 1'b1;
         end
         if (bus.mode == exp) break;
      end
      bus.key_mode = 1'b1;
      bus.key_step = 1'b1;
      chk("mode_press", int'(bus.mode), int'(exp));
   endtask

   task automatic step_check(input string nm, input logic [2:0] exp, input bit poke);
      logic [2:0] start;
      int n;
      start = idx();
      n = 0;
      while (n < 15) begin
         @(negedge clk);
         n++;
         if (poke) bus.key_step = (n < 5) ? 1'b0 : 1'b1;
         if (idx() != start) break;
      end
      bus.key_step = 1'b1;
      chk({nm, "_gap"}, n, 10);
      chk(nm, int'(idx()), int'(exp));
      chk({nm, "_tick"}, int'(bus.tick), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by 200000 expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 10, 1'b0, 3'd1, 2'd0, "step10"};
      tbl[1]  = '{1'b1,  3, 1'b0, 3'd1, 2'd0, "glitch3"};
      tbl[2]  = '{1'b1,  4, 1'b0, 3'd2, 2'd0, "step4"};
      tbl[3]  = '{1'b1,  2, 1'b0, 3'd2, 2'd0, "glitch2"};
      tbl[4]  = '{1'b1, 10, 1'b1, 3'd3, 2'd0, "bounce"};
      tbl[5]  = '{1'b1, 10, 1'b0, 3'd4, 2'd0, "step_a"};
      tbl[6]  = '{1'b1, 10, 1'b0, 3'd5, 2'd0, "step_b"};
      tbl[7]  = '{1'b1, 10, 1'b0, 3'd6, 2'd0, "step_c"};
      tbl[8]  = '{1'b1, 10, 1'b0, 3'd7, 2'd0, "step_d"};
      tbl[9]  = '{1'b1, 10, 1'b0, 3'd0, 2'd0, "step_wrap"};
      tbl[10] = '{1'b0,  3, 1'b0, 3'd0, 2'd0, "mglitch3"};

      bus.key_mode = 1'b1;
      bus.key_step = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_abc",  int'(idx()),     0);
      chk("rst_mode", int'(bus.mode),  0);
      chk("rst_tick", int'(bus.tick),  0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         pulse_key(tbl[i].key, tbl[i].low, tbl[i].bounce);
         chk({tbl[i].nm, "_idx"},  int'(idx()),    int'(tbl[i].e_idx));
         chk({tbl[i].nm, "_mode"}, int'(bus.mode), int'(tbl[i].e_mode));
      end

      press_mode_wait(2'd1, 1'b0, lat);
      for (int k = 0; k < 9; k++) begin
         step_check($sformatf("up%0d", k), 3'((k + 1) % 8), k == 3);
      end
      chk("up_mode", int'(bus.mode), 1);

      repeat (3) @(negedge clk);
      press_mode_wait(2'd2, 1'b0, lat);
      chk("coll_lat",  lat, 7);
      chk("coll_idx",  int'(idx()),    1);
      chk("coll_tick", int'(bus.tick), 0);
      step_check("down0", 3'd0, 1'b0);
      step_check("down7", 3'd7, 1'b0);
      step_check("down6", 3'd6, 1'b0);
      step_check("down5", 3'd5, 1'b0);

      @(negedge clk);
      press_mode_wait(2'd3, 1'b0, lat);
      chk("pp_entry_idx", int'(idx()), 5);
      step_check("pp6a", 3'd6, 1'b0);
      step_check("pp7",  3'd7, 1'b0);
      step_check("pp6b", 3'd6, 1'b0);
      step_check("pp5",  3'd5, 1'b0);
      step_check("pp4",  3'd4, 1'b0);
      step_check("pp3",  3'd3, 1'b0);
      step_check("pp2a", 3'd2, 1'b0);
      step_check("pp1a", 3'd1, 1'b0);
      step_check("pp0",  3'd0, 1'b0);
      step_check("pp1b", 3'd1, 1'b0);
      step_check("pp2b", 3'd2, 1'b0);

      @(negedge clk);
      press_mode_wait(2'd0, 1'b0, lat);
      repeat (30) @(negedge clk);
      chk("hold_idx", int'(idx()), 2);
      press_mode_wait(2'd1, 1'b1, lat);
      chk("both_idx", int'(idx()), 3);

      repeat (12) @(negedge clk);
      bus.key_mode = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_abc",  int'(idx()),    0);
      chk("mid_rst_mode", int'(bus.mode), 0);
      chk("mid_rst_tick", int'(bus.tick), 0);
      repeat (3) @(negedge clk);
      bus.key_mode = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         chk($sformatf("idle_tick%0d", i), int'(bus.tick), (i % 10 == 0) ? 1 : 0);
      end
      chk("idle_idx",  int'(idx()),    0);
      chk("idle_mode", int'(bus.mode), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
